// File: rtl/memory_stage.sv
// Memory pipeline stage: drives a req/ack data bus for loads and stores,
// stalls upstream while an access is outstanding, and holds the MEM/WB register.
module memory_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] LUI_or_AUIPCM,
   input  logic [31:0] PCPlus4M,
   input  logic [2:0]  ResultSrcM,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [4:0]  rdM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        StallM2H,
   output logic        MemErrM2H,
   output logic        MisalignM2H,
   output logic [31:0] ALUOutW,
   output logic [31:0] ReadDataMemW,
   output logic [31:0] LUI_or_AUIPCW,
   output logic [31:0] PCPlus4W,
   output logic [2:0]  ResultSrcW,
   output logic        RegWriteW,
   output logic [4:0]  rdW
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t     state_reg;
   logic [7:0] count_reg;

   logic [1:0] off;
   logic       is_load, is_store, is_memop;
   logic       is_byte, is_half;
   logic       misaligned, aligned_memop;
   logic       timeout, complete, abort;

   always_comb begin
      off      = ALUOutM[1:0];
      is_load  = (ResultSrcM >= 3'd2) && (ResultSrcM <= 3'd6);
      is_store = MemWriteM;
      is_memop = is_load | is_store;
      is_byte  = 1'b0;
      is_half  = 1'b0;
      // Stores are sized by funct3, loads by their result select.
      if (is_store) begin
         is_byte = (funct3M == 3'b000);
         is_half = (funct3M == 3'b001);
      end else begin
         is_byte = (ResultSrcM == 3'd2) || (ResultSrcM == 3'd5);
         is_half = (ResultSrcM == 3'd3) || (ResultSrcM == 3'd6);
      end
      if (is_byte)
         misaligned = 1'b0;
      else if (is_half)
         misaligned = is_memop & off[0];
      else
         misaligned = is_memop & (off != 2'b00);
      aligned_memop = is_memop & ~misaligned;
   end

   // Counter holds the cycles already waited; this cycle would reach the limit.
   assign timeout = (state_reg == WAIT) &&
                    ((32'(count_reg) + 32'd1) >= TIMEOUT_CYCLES);

   // A late ack in the timeout cycle still completes, so req stays up with it.
   assign dmem_req = ~reset &
                     (((state_reg == IDLE) & aligned_memop) |
                      ((state_reg == WAIT) & (~timeout | dmem_ack)));
   assign dmem_we   = is_store;
   assign dmem_addr = {ALUOutM[31:2], 2'b00};
   assign complete  = dmem_req & dmem_ack;
   assign abort     = ~reset & timeout & ~dmem_ack;

   assign StallM2H    = ~reset &
                        (((state_reg == IDLE) & aligned_memop & ~dmem_ack) |
                         ((state_reg == WAIT) & ~dmem_ack & ~timeout));
   assign MemErrM2H   = abort;
   assign MisalignM2H = ~reset & (state_reg == IDLE) & misaligned;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         always_comb begin
            case (funct3M)
               3'b000:  dmem_wdata[8*gi +: 8] = WriteDataM[7:0];
               3'b001:  dmem_wdata[8*gi +: 8] = WriteDataM[8*(gi%2) +: 8];
               default: dmem_wdata[8*gi +: 8] = WriteDataM[8*gi +: 8];
            endcase
         end
      end
   endgenerate

   always_comb begin
      dmem_wstrb = 4'b0000;
      if (is_store) begin
         case (funct3M)
            3'b000:  dmem_wstrb = 4'b0001 << off;
            3'b001:  dmem_wstrb = 4'b0011 << off;
            default: dmem_wstrb = 4'b1111;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         count_reg <= 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (aligned_memop && !dmem_ack) begin
                  state_reg <= WAIT;
                  count_reg <= 8'd1;
               end
            end
            WAIT: begin
               if (dmem_ack || timeout) begin
                  state_reg <= IDLE;
                  count_reg <= 8'd0;
               end else begin
                  count_reg <= count_reg + 8'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
               count_reg <= 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ALUOutW       <= 32'd0;
         ReadDataMemW  <= 32'd0;
         LUI_or_AUIPCW <= 32'd0;
         PCPlus4W      <= 32'd0;
         ResultSrcW    <= 3'd0;
         RegWriteW     <= 1'b0;
         rdW           <= 5'd0;
      end else if (!StallM2H) begin
         ALUOutW       <= ALUOutM;
         LUI_or_AUIPCW <= LUI_or_AUIPCM;
         PCPlus4W      <= PCPlus4M;
         ResultSrcW    <= ResultSrcM;
         RegWriteW     <= RegWriteM & ~misaligned & ~abort;
         rdW           <= rdM;
         if (complete)
            ReadDataMemW <= dmem_rdata >> {off, 3'b000};
      end else begin
         RegWriteW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, reset-in-wait
// sequence, and randomized ops checked against a size/offset reference model.
module tb_memory_stage;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ALUOutM, WriteDataM, LUI_or_AUIPCM, PCPlus4M;
   logic [2:0]  ResultSrcM, funct3M;
   logic        RegWriteM, MemWriteM;
   logic [4:0]  rdM;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic        StallM2H, MemErrM2H, MisalignM2H;
   logic [31:0] ALUOutW, ReadDataMemW, LUI_or_AUIPCW, PCPlus4W;
   logic [2:0]  ResultSrcW;
   logic        RegWriteW;
   logic [4:0]  rdW;

   memory_stage #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .LUI_or_AUIPCM(LUI_or_AUIPCM),
      .PCPlus4M(PCPlus4M), .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM),
      .MemWriteM(MemWriteM), .funct3M(funct3M), .rdM(rdM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .StallM2H(StallM2H), .MemErrM2H(MemErrM2H),
      .MisalignM2H(MisalignM2H), .ALUOutW(ALUOutW), .ReadDataMemW(ReadDataMemW),
      .LUI_or_AUIPCW(LUI_or_AUIPCW), .PCPlus4W(PCPlus4W), .ResultSrcW(ResultSrcW),
      .RegWriteW(RegWriteW), .rdW(rdW)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] addr, wd, rdata;
      logic [2:0]  rs, f3;
      logic        mw, rw;
      logic [4:0]  rd;
      int          lat;       // cycle index of ack; >= T means never in time
      logic [31:0] e_daddr, e_wdata;
      logic [3:0]  e_wstrb;
      logic        e_mis;
      logic [31:0] e_rdw;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: expected bus values from access size and byte offset.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int size, off;
      logic is_load;
      is_load = (v.rs >= 3'd2) && (v.rs <= 3'd6);
      off = int'(v.addr % 4);
      if (v.mw)
         size = (v.f3 == 3'd0) ? 1 : (v.f3 == 3'd1) ? 2 : 4;
      else
         size = (v.rs == 3'd2 || v.rs == 3'd5) ? 1 : (v.rs == 3'd3 || v.rs == 3'd6) ? 2 : 4;
      r.e_mis   = (is_load || v.mw) && ((off % size) != 0);
      r.e_daddr = v.addr - 32'(off);
      if (size == 1)      r.e_wdata = 32'(v.wd % 256) * 32'h01010101;
      else if (size == 2) r.e_wdata = 32'(v.wd % 65536) * 32'h00010001;
      else                r.e_wdata = v.wd;
      r.e_wstrb = v.mw ? 4'(((1 << size) - 1) << off) : 4'd0;
      r.e_rdw   = v.rdata / (32'd1 << (8 * off));
      return r;
   endfunction

   // Called at a negedge; returns at a negedge after checking the W register.
   task automatic run_op(input vec_t v, input string tag);
      logic is_load, aligned, tmo, exp_req;
      int kend;
      is_load = (v.rs >= 3'd2) && (v.rs <= 3'd6);
      aligned = (is_load || v.mw) && !v.e_mis;
      kend    = aligned ? ((v.lat < T - 1) ? v.lat : T - 1) : 0;
      tmo     = aligned && (v.lat > T - 1);
      ALUOutM = v.addr; WriteDataM = v.wd; LUI_or_AUIPCM = v.wd ^ 32'h5A5A5A5A;
      PCPlus4M = v.addr + 32'd4; ResultSrcM = v.rs; funct3M = v.f3;
      MemWriteM = v.mw; RegWriteM = v.rw; rdM = v.rd;
      for (int k = 0; k <= kend; k++) begin
         if (k > 0) @(negedge clk);
         dmem_ack   = aligned && (k == v.lat);
         dmem_rdata = dmem_ack ? v.rdata : $urandom;
         #1;
         exp_req = aligned && !(tmo && k == T - 1);
         chk({tag, ".req"}, dmem_req, exp_req);
         if (exp_req) begin
            chk({tag, ".addr"}, dmem_addr, v.e_daddr);
            chk({tag, ".we"}, dmem_we, v.mw);
            chk({tag, ".wstrb"}, dmem_wstrb, v.e_wstrb);
            if (v.mw) chk({tag, ".wdata"}, dmem_wdata, v.e_wdata);
         end
         chk({tag, ".stall"}, StallM2H, aligned && (k < kend));
         chk({tag, ".misalign"}, MisalignM2H, v.e_mis);
         chk({tag, ".memerr"}, MemErrM2H, tmo && (k == T - 1));
         if (k > 0) chk({tag, ".bubble_in_stall"}, RegWriteW, 1'b0);
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      chk({tag, ".wfields"}, {ALUOutW, LUI_or_AUIPCW, PCPlus4W, ResultSrcW, rdW},
          {v.addr, v.wd ^ 32'h5A5A5A5A, v.addr + 32'd4, v.rs, v.rd});
      chk({tag, ".regwrite"}, RegWriteW, v.rw && !v.e_mis && !tmo);
      if (is_load && aligned && !tmo) chk({tag, ".rdata"}, ReadDataMemW, v.e_rdw);
      $display("op %s addr=%h rs=%0d mw=%0d lat=%0d -> RegWriteW=%0d ReadDataMemW=%h",
               tag, v.addr, v.rs, v.mw, v.lat, RegWriteW, ReadDataMemW);
   endtask

   vec_t tbl[11];
   vec_t rv;

   initial begin
      // addr, wd, rdata, rs, f3, mw, rw, rd, lat, e_daddr, e_wdata, e_wstrb, e_mis, e_rdw
      tbl[0]  = '{32'h1234, 32'h0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b1, 5'd5, 0,
                  32'h1234, 32'h0, 4'h0, 1'b0, 32'h0};
      tbl[1]  = '{32'h103, 32'h0, 32'h80AABBCC, 3'd2, 3'd0, 1'b0, 1'b1, 5'd7, 0,
                  32'h100, 32'h0, 4'h0, 1'b0, 32'h00000080};
      tbl[2]  = '{32'h202, 32'hDEADBEEF, 32'h0, 3'd0, 3'd1, 1'b1, 1'b0, 5'd0, 3,
                  32'h200, 32'hBEEFBEEF, 4'hC, 1'b0, 32'h0};
      tbl[3]  = '{32'h006, 32'h0, 32'h0, 3'd4, 3'd0, 1'b0, 1'b1, 5'd9, 0,
                  32'h004, 32'h0, 4'h0, 1'b1, 32'h0};
      tbl[4]  = '{32'h300, 32'h0, 32'h0, 3'd4, 3'd0, 1'b0, 1'b1, 5'd10, 255,
                  32'h300, 32'h0, 4'h0, 1'b0, 32'h0};
      tbl[5]  = '{32'h001, 32'h123456A5, 32'h0, 3'd0, 3'd0, 1'b1, 1'b0, 5'd0, 1,
                  32'h000, 32'hA5A5A5A5, 4'h2, 1'b0, 32'h0};
      tbl[6]  = '{32'h402, 32'h0, 32'hCAFE1234, 3'd6, 3'd0, 1'b0, 1'b1, 5'd11, 2,
                  32'h400, 32'h0, 4'h0, 1'b0, 32'h0000CAFE};
      tbl[7]  = '{32'h010, 32'h11223344, 32'h0, 3'd0, 3'd3, 1'b1, 1'b0, 5'd0, 0,
                  32'h010, 32'h11223344, 4'hF, 1'b0, 32'h0};
      tbl[8]  = '{32'h001, 32'h0, 32'h0, 3'd3, 3'd0, 1'b0, 1'b1, 5'd12, 0,
                  32'h000, 32'h0, 4'h0, 1'b1, 32'h0};
      tbl[9]  = '{32'h8000, 32'h0, 32'h0, 3'd7, 3'd0, 1'b0, 1'b1, 5'd1, 0,
                  32'h8000, 32'h0, 4'h0, 1'b0, 32'h0};
      tbl[10] = '{32'h013, 32'h55667788, 32'h0, 3'd0, 3'd2, 1'b1, 1'b0, 5'd0, 0,
                  32'h010, 32'h55667788, 4'hF, 1'b1, 32'h0};

      reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      ALUOutM = 32'h0; WriteDataM = 32'h0; LUI_or_AUIPCM = 32'h0; PCPlus4M = 32'h0;
      ResultSrcM = 3'd0; funct3M = 3'd0; MemWriteM = 1'b0; RegWriteM = 1'b0; rdM = 5'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset.wregs", {ALUOutW, ReadDataMemW, LUI_or_AUIPCW, PCPlus4W, ResultSrcW, RegWriteW, rdW}, 128'd0);
      chk("reset.outs", {dmem_req, StallM2H, MemErrM2H, MisalignM2H}, 4'b0000);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) run_op(tbl[i], $sformatf("vec%0d", i));

      // Reset while waiting on a load abandons it; next load issues from IDLE.
      ALUOutM = 32'h40; ResultSrcM = 3'd4; MemWriteM = 1'b0; RegWriteM = 1'b1; rdM = 5'd3;
      #1;
      chk("rstwait.req_idle", dmem_req, 1'b1);
      @(negedge clk); #1;
      chk("rstwait.stall", StallM2H, 1'b1);
      reset = 1'b1; #1;
      chk("rstwait.req_drop", dmem_req, 1'b0);
      @(negedge clk); #1;
      chk("rstwait.wregs", {ALUOutW, ReadDataMemW, LUI_or_AUIPCW, PCPlus4W, ResultSrcW, RegWriteW, rdW}, 128'd0);
      reset = 1'b0;
      $display("op rstwait: load abandoned by reset");
      rv = '{32'h40, 32'h0, 32'h01020304, 3'd4, 3'd0, 1'b0, 1'b1, 5'd3, 0,
             32'h40, 32'h0, 4'h0, 1'b0, 32'h01020304};
      run_op(rv, "after_reset");

      for (int i = 0; i < 120; i++) begin
         int pick;
         rv.addr = $urandom; rv.wd = $urandom; rv.rdata = $urandom;
         rv.rd = 5'($urandom); rv.rw = 1'($urandom); rv.f3 = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            rv.mw = 1'b1; rv.rs = 3'd0;
         end else begin
            rv.mw = 1'b0; rv.rs = 3'($urandom_range(0, 7));
         end
         pick = int'($urandom_range(0, 5));
         rv.lat = (pick == 5) ? 255 : pick;
         rv = model(rv);
         run_op(rv, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
